vector_lsu: RTL and testbench
=============================

VECTOR_LSU -- requirements
Module: vector_lsu

Interface
REQ-001 Parameters SHALL be: DATA_BITS, default 8, scalar word width; Vector_Size, default 4, lanes per vector register; ADDR_BITS, default 8, data-memory address width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- enable  in  1  thread active; low freezes all state
- core_state  in  3  core stage; 011=REQUEST, 110=UPDATE
- decoded_mem_read_enable  in  1  LDR
- decoded_mem_write_enable  in  1  STR
- decoded_vector_mux  in  1  1 = vector access
- rs  in  8  base address
- rt  in  DATA_BITS  scalar store data
- v_rt  in  Vector_Size*DATA_BITS  vector store data, lane i at bits [i*DATA_BITS +: DATA_BITS]
- mem_read_valid  out  1  read request
- mem_read_address  out  ADDR_BITS  read address
- mem_read_ready  in  1  read data valid and request accepted
- mem_read_data  in  DATA_BITS  read data
- mem_write_valid  out  1  write request
- mem_write_address  out  ADDR_BITS  write address
- mem_write_data  out  DATA_BITS  write data
- mem_write_ready  in  1  write accepted
- lsu_state  out  2  00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
- lsu_out  out  DATA_BITS  scalar load result
- v_lsu_out  out  Vector_Size*DATA_BITS  vector load result

Function
REQ-003 All outputs SHALL be registered; no combinational path from an input to an output.
REQ-004 In IDLE with core_state=REQUEST and exactly one of read/write enable set, the FSM SHALL move to REQUESTING next cycle, with lane index cleared to 0 and access count = Vector_Size if decoded_vector_mux=1, else 1.
REQ-005 If read and write enables are both set, the FSM SHALL treat the access as a read and ignore the write.
REQ-006 In REQUESTING, the block SHALL assert the selected valid for one cycle, with address = (rs + lane) mod 2^ADDR_BITS and write data = rt (scalar) or v_rt lane slice (vector), and then move to WAITING.
REQ-007 In WAITING, valid and address/data SHALL stay held until the matching ready is sampled high.
REQ-008 When ready is sampled high in WAITING, valid SHALL drop the next cycle. A read SHALL load mem_read_data into lsu_out (scalar) or v_lsu_out lane (vector).
REQ-009 After REQ-008, if lane = count-1 the FSM SHALL go to DONE; otherwise lane SHALL increment and the FSM SHALL return to REQUESTING.
REQ-010 DONE SHALL hold until core_state=UPDATE, then return to IDLE; lsu_out and v_lsu_out SHALL keep their values until overwritten by a later load.
REQ-011 A vector load SHALL update only the lanes it has completed; untouched lanes keep prior values. A scalar load SHALL leave v_lsu_out unchanged, and a vector load SHALL leave lsu_out unchanged.
REQ-012 Ready arriving outside WAITING, or ready on the non-selected channel, SHALL be ignored.
REQ-013 With enable=0, state, lane, outputs and valids SHALL hold.
REQ-014 Address wrap SHALL be modulo 2^ADDR_BITS with no error flag.
REQ-015 Scalar access latency SHALL be: IDLE -> REQUESTING in 1 cycle, valid high 1 cycle later, DONE 1 cycle after ready.

Reset
REQ-016 Assertion of reset SHALL immediately force, asynchronously: lsu_state=IDLE, lane=0, mem_read_valid=0, mem_write_valid=0, all addresses, write data, lsu_out and v_lsu_out = 0.
REQ-017 Reset during an outstanding access SHALL abandon it without completing; a ready sampled in the first cycle after reset release SHALL be ignored.

Structure
REQ-018 LSU state encodings and core_state encodings (REQUEST, UPDATE) SHALL live in a shared core package used by this block, the register file and the scheduler.
REQ-019 The design SHALL be a single module with one FSM; the lane counter width SHALL be $clog2(Vector_Size)+1.

Verification
REQ-020 Scalar LDR: rs=0x10, mem returns 0xAB with ready 2 cycles after valid -> lsu_out=0xAB, DONE, back to IDLE on UPDATE.
REQ-021 Vector LDR: rs=0xFE, Vector_Size=4 -> read addresses 0xFE, 0xFF, 0x00, 0x01; data 1, 2, 3, 4 -> v_lsu_out=0x04030201.
REQ-022 Vector STR: rs=0x20, v_rt=0xDDCCBBAA -> writes (0x20,AA), (0x21,BB), (0x22,CC), (0x23,DD), each valid held until ready.
REQ-023 Both enables set: rs=0x05 -> only mem_read_valid asserted, mem_write_valid stays 0.
REQ-024 Reset asserted during lane 2 WAITING -> valids drop immediately, state IDLE, v_lsu_out=0; a stray ready after release produces no capture.
REQ-025 enable=0 for 3 cycles in WAITING with ready pulsing -> no state change; after enable=1, the next ready completes normally.

Source files
------------

// File: rtl/vector_lsu_pkg.sv
// rtl/vector_lsu_pkg.sv - shared core encodings for LSU state and core pipeline stage
package vector_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

endpackage

// File: rtl/vector_lsu.sv
// rtl/vector_lsu.sv - scalar/vector load-store unit, one memory beat per lane
module vector_lsu
  import vector_lsu_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int Vector_Size = 4,
  parameter int ADDR_BITS   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       core_state,
  input  logic                             decoded_mem_read_enable,
  input  logic                             decoded_mem_write_enable,
  input  logic                             decoded_vector_mux,
  input  logic [7:0]                       rs,
  input  logic [DATA_BITS-1:0]             rt,
  input  logic [Vector_Size*DATA_BITS-1:0] v_rt,
  output logic                             mem_read_valid,
  output logic [ADDR_BITS-1:0]             mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [DATA_BITS-1:0]             mem_read_data,
  output logic                             mem_write_valid,
  output logic [ADDR_BITS-1:0]             mem_write_address,
  output logic [DATA_BITS-1:0]             mem_write_data,
  input  logic                             mem_write_ready,
  output logic [1:0]                       lsu_state,
  output logic [DATA_BITS-1:0]             lsu_out,
  output logic [Vector_Size*DATA_BITS-1:0] v_lsu_out
);

  localparam int LW = $clog2(Vector_Size) + 1;

  lsu_state_t    state_q, state_d;
  logic [LW-1:0] lane_q, lane_d, count_q, count_d;
  logic          is_read_q, is_read_d, is_vec_q, is_vec_d;
  logic          ready_hit, last_lane;

  logic                             rvalid_d, wvalid_d;
  logic [ADDR_BITS-1:0]             raddr_d, waddr_d, req_addr;
  logic [DATA_BITS-1:0]             wdata_d, lsu_out_d;
  logic [Vector_Size*DATA_BITS-1:0] v_lsu_out_d;

  // Only the channel chosen at launch can complete the beat.
  assign ready_hit = is_read_q ? mem_read_ready : mem_write_ready;
  assign last_lane = (lane_q == count_q - LW'(1));
  assign req_addr  = ADDR_BITS'(rs) + ADDR_BITS'(lane_q);
  assign lsu_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= LSU_IDLE;
      lane_q            <= '0;
      count_q           <= '0;
      is_read_q         <= 1'b0;
      is_vec_q          <= 1'b0;
      mem_read_valid    <= 1'b0;
      mem_write_valid   <= 1'b0;
      mem_read_address  <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_out           <= '0;
      v_lsu_out         <= '0;
    end else if (enable) begin
      state_q           <= state_d;
      lane_q            <= lane_d;
      count_q           <= count_d;
      is_read_q         <= is_read_d;
      is_vec_q          <= is_vec_d;
      mem_read_valid    <= rvalid_d;
      mem_write_valid   <= wvalid_d;
      mem_read_address  <= raddr_d;
      mem_write_address <= waddr_d;
      mem_write_data    <= wdata_d;
      lsu_out           <= lsu_out_d;
      v_lsu_out         <= v_lsu_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    count_d   = count_q;
    is_read_d = is_read_q;
    is_vec_d  = is_vec_q;
    case (state_q)
      LSU_IDLE: begin
        // A read wins when both enables are set.
        if (core_state == CORE_REQUEST &&
            (decoded_mem_read_enable || decoded_mem_write_enable)) begin
          state_d   = LSU_REQUESTING;
          lane_d    = '0;
          count_d   = decoded_vector_mux ? LW'(Vector_Size) : LW'(1);
          is_read_d = decoded_mem_read_enable;
          is_vec_d  = decoded_vector_mux;
        end
      end
      LSU_REQUESTING: state_d = LSU_WAITING;
      LSU_WAITING: begin
        if (ready_hit) begin
          if (last_lane) begin
            state_d = LSU_DONE;
          end else begin
            state_d = LSU_REQUESTING;
            lane_d  = lane_q + LW'(1);
          end
        end
      end
      LSU_DONE: if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
      default: state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    rvalid_d    = mem_read_valid;
    wvalid_d    = mem_write_valid;
    raddr_d     = mem_read_address;
    waddr_d     = mem_write_address;
    wdata_d     = mem_write_data;
    lsu_out_d   = lsu_out;
    v_lsu_out_d = v_lsu_out;
    case (state_q)
      LSU_REQUESTING: begin
        if (is_read_q) begin
          rvalid_d = 1'b1;
          raddr_d  = req_addr;
        end else begin
          wvalid_d = 1'b1;
          waddr_d  = req_addr;
          wdata_d  = rt;
          if (is_vec_q) begin
            for (int i = 0; i < Vector_Size; i++)
              if (lane_q == LW'(i)) wdata_d = v_rt[i*DATA_BITS +: DATA_BITS];
          end
        end
      end
      LSU_WAITING: begin
        if (ready_hit) begin
          rvalid_d = 1'b0;
          wvalid_d = 1'b0;
          if (is_read_q) begin
            if (is_vec_q) begin
              for (int i = 0; i < Vector_Size; i++)
                if (lane_q == LW'(i)) v_lsu_out_d[i*DATA_BITS +: DATA_BITS] = mem_read_data;
            end else begin
              lsu_out_d = mem_read_data;
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vector_lsu.sv
// tb/tb_vector_lsu.sv - directed table-driven bench for vector_lsu
module tb_vector_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  core_state;
  logic        decoded_mem_read_enable, decoded_mem_write_enable, decoded_vector_mux;
  logic [7:0]  rs, rt;
  logic [31:0] v_rt;
  logic        mem_read_valid, mem_read_ready;
  logic [7:0]  mem_read_address, mem_read_data;
  logic        mem_write_valid, mem_write_ready;
  logic [7:0]  mem_write_address, mem_write_data;
  logic [1:0]  lsu_state;
  logic [7:0]  lsu_out;
  logic [31:0] v_lsu_out;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] CS_REQUEST = 3'b011;
  localparam logic [2:0] CS_UPDATE  = 3'b110;
  localparam logic [2:0] CS_OTHER   = 3'b000;

  vector_lsu dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(decoded_mem_read_enable),
    .decoded_mem_write_enable(decoded_mem_write_enable),
    .decoded_vector_mux(decoded_vector_mux),
    .rs(rs), .rt(rt), .v_rt(v_rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .v_lsu_out(v_lsu_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd, wr, vec;
    logic [7:0]  rs_v, rt_v;
    logic [31:0] vrt_v, rdata_v;
    int          delay;
    logic [7:0]  exp_lsu;
    logic [31:0] exp_vlsu;
  } vec_t;

  // Drives one complete access lane by lane, acting as the memory.
  task automatic run_access(input logic rd, input logic wr, input logic vec,
                            input logic [7:0] rs_i, input logic [7:0] rt_i,
                            input logic [31:0] vrt_i, input logic [31:0] rdata_i,
                            input int delay);
    int n;
    logic rsel;
    logic [7:0] ea, ed;
    n = vec ? 4 : 1;
    rsel = rd;
    decoded_mem_read_enable = rd;
    decoded_mem_write_enable = wr;
    decoded_vector_mux = vec;
    rs = rs_i; rt = rt_i; v_rt = vrt_i;
    core_state = CS_REQUEST;
    tick();
    check("start_requesting", lsu_state, 2'b01);
    core_state = CS_OTHER;
    for (int i = 0; i < n; i++) begin
      tick();
      ea = 8'(int'(rs_i) + i);
      ed = vec ? vrt_i[i*8 +: 8] : rt_i;
      check("waiting_state", lsu_state, 2'b10);
      check("sel_valid", rsel ? mem_read_valid : mem_write_valid, 1'b1);
      check("other_valid", rsel ? mem_write_valid : mem_read_valid, 1'b0);
      check("address", rsel ? mem_read_address : mem_write_address, ea);
      if (!rsel) check("write_data", mem_write_data, ed);
      for (int d = 0; d < delay; d++) begin
        if (rsel) mem_write_ready = 1'b1; else mem_read_ready = 1'b1;
        tick();
        mem_write_ready = 1'b0; mem_read_ready = 1'b0;
        check("held_valid", rsel ? mem_read_valid : mem_write_valid, 1'b1);
        check("held_addr", rsel ? mem_read_address : mem_write_address, ea);
      end
      if (rsel) begin
        mem_read_ready = 1'b1;
        mem_read_data = rdata_i[i*8 +: 8];
      end else begin
        mem_write_ready = 1'b1;
      end
      tick();
      mem_read_ready = 1'b0; mem_write_ready = 1'b0;
      check("valid_drop", rsel ? mem_read_valid : mem_write_valid, 1'b0);
      check("after_ready_state", lsu_state, (i == n - 1) ? 2'b11 : 2'b01);
    end
    core_state = CS_UPDATE;
    tick();
    check("update_idle", lsu_state, 2'b00);
    core_state = CS_OTHER;
    decoded_mem_read_enable = 1'b0;
    decoded_mem_write_enable = 1'b0;
    decoded_vector_mux = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1, 0, 0, 8'h10, 8'h00, 32'h0, 32'h000000AB, 2, 8'hAB, 32'h00000000};
    tbl[1] = '{1, 0, 1, 8'hFE, 8'h00, 32'h0, 32'h04030201, 1, 8'hAB, 32'h04030201};
    tbl[2] = '{0, 1, 1, 8'h20, 8'h00, 32'hDDCCBBAA, 32'h0, 2, 8'hAB, 32'h04030201};
    tbl[3] = '{1, 1, 0, 8'h05, 8'h00, 32'h0, 32'h0000005A, 1, 8'h5A, 32'h04030201};
    tbl[4] = '{0, 1, 0, 8'hFF, 8'h77, 32'h0, 32'h0, 0, 8'h5A, 32'h04030201};
    tbl[5] = '{1, 0, 0, 8'h00, 8'h00, 32'h0, 32'h00000000, 0, 8'h00, 32'h04030201};

    reset = 1'b1; enable = 1'b1; core_state = CS_OTHER;
    decoded_mem_read_enable = 0; decoded_mem_write_enable = 0; decoded_vector_mux = 0;
    rs = 0; rt = 0; v_rt = 0;
    mem_read_ready = 0; mem_read_data = 0; mem_write_ready = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_state", lsu_state, 2'b00);
    check("rst_rvalid", mem_read_valid, 1'b0);
    check("rst_wvalid", mem_write_valid, 1'b0);
    check("rst_lsu_out", lsu_out, 8'h00);
    check("rst_v_lsu_out", v_lsu_out, 32'h0);

    for (int t = 0; t < 6; t++) begin
      run_access(tbl[t].rd, tbl[t].wr, tbl[t].vec, tbl[t].rs_v, tbl[t].rt_v,
                 tbl[t].vrt_v, tbl[t].rdata_v, tbl[t].delay);
      check("tbl_lsu_out", lsu_out, tbl[t].exp_lsu);
      check("tbl_v_lsu_out", v_lsu_out, tbl[t].exp_vlsu);
    end

    // Reset while lane 2 of a vector load is outstanding.
    decoded_mem_read_enable = 1; decoded_vector_mux = 1; rs = 8'h40;
    core_state = CS_REQUEST;
    tick();
    core_state = CS_OTHER;
    tick();
    mem_read_ready = 1; mem_read_data = 8'h11;
    tick();
    mem_read_ready = 0;
    tick();
    mem_read_ready = 1; mem_read_data = 8'h22;
    tick();
    mem_read_ready = 0;
    tick();
    check("rst_mid_addr", mem_read_address, 8'h42);
    check("rst_mid_partial", v_lsu_out, 32'h04032211);
    #2 reset = 1'b1;
    #1;
    check("async_rvalid", mem_read_valid, 1'b0);
    check("async_state", lsu_state, 2'b00);
    check("async_v_lsu_out", v_lsu_out, 32'h0);
    check("async_addr", mem_read_address, 8'h00);
    decoded_mem_read_enable = 0; decoded_vector_mux = 0;
    tick();
    reset = 1'b0;
    mem_read_ready = 1; mem_read_data = 8'hEE;
    tick();
    mem_read_ready = 0;
    check("stray_state", lsu_state, 2'b00);
    check("stray_v_lsu_out", v_lsu_out, 32'h0);
    check("stray_lsu_out", lsu_out, 8'h00);
    check("stray_rvalid", mem_read_valid, 1'b0);

    // enable low in WAITING freezes everything despite ready pulses.
    decoded_mem_read_enable = 1; rs = 8'h30;
    core_state = CS_REQUEST;
    tick();
    core_state = CS_OTHER;
    tick();
    check("frz_addr", mem_read_address, 8'h30);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_read_ready = (k % 2 == 0); mem_read_data = 8'h99;
      tick();
      check("frz_state", lsu_state, 2'b10);
      check("frz_rvalid", mem_read_valid, 1'b1);
      check("frz_lsu_out", lsu_out, 8'h00);
    end
    enable = 1'b1; mem_read_ready = 0;
    tick();
    check("resume_wait", lsu_state, 2'b10);
    mem_read_ready = 1; mem_read_data = 8'h3C;
    tick();
    mem_read_ready = 0;
    check("resume_done", lsu_state, 2'b11);
    check("resume_lsu_out", lsu_out, 8'h3C);
    check("resume_rvalid", mem_read_valid, 1'b0);
    tick();
    check("done_hold", lsu_state, 2'b11);
    core_state = CS_UPDATE;
    tick();
    check("resume_idle", lsu_state, 2'b00);
    core_state = CS_OTHER;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
